// File: rtl/dice_pkg.sv
// Shared types and constants for the dice score keeper.
// The DICE_HIST_EN build adds per-face roll counters on top of these.
package dice_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROLLING = 3'd1,
    SCORE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [2:0] FACE_MIN   = 3'd1;
  localparam logic [2:0] FACE_MAX   = 3'd6;
  localparam logic [2:0] BONUS_FACE = 3'd6;
  localparam int         NUM_FACES  = 6;
  localparam int         HIST_W     = 16;

  function automatic logic face_ok(input logic [2:0] f);
    return (f >= FACE_MIN) && (f <= FACE_MAX);
  endfunction

endpackage

// File: rtl/dice_score_keeper_if.sv
// Button/throw inputs and score/status outputs of the dice score keeper.
// Histogram read port exists only when DICE_HIST_EN is defined.
interface dice_score_keeper_if #(parameter int SCORE_W = 8);
  logic               button;
  logic [2:0]         throw;
  logic               new_game;
  logic               player;
  logic [SCORE_W-1:0] score0;
  logic [SCORE_W-1:0] score1;
  logic [2:0]         last_throw;
  logic               result_valid;
  logic               bad_throw;
  logic               game_over;
  logic               winner;
`ifdef DICE_HIST_EN
  logic [2:0]         hist_sel;
  logic [15:0]        hist_count;
`endif

  modport master (
    output button, throw, new_game,
    input  player, score0, score1, last_throw, result_valid, bad_throw, game_over, winner
`ifdef DICE_HIST_EN
    , output hist_sel
    , input  hist_count
`endif
  );

  modport slave (
    input  button, throw, new_game,
    output player, score0, score1, last_throw, result_valid, bad_throw, game_over, winner
`ifdef DICE_HIST_EN
    , input  hist_sel
    , output hist_count
`endif
  );
endinterface

// File: rtl/dice_release_det.sv
// Registers the roll button once and derives single-cycle press/release pulses.
module dice_release_det (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press,
  output logic rel
);
  logic btn_q;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= button;
  end

  assign press = ~btn_q &  button;
  assign rel   =  btn_q & ~button;
endmodule

// File: rtl/dice_score_keeper.sv
// Two-player running score for the electronic dice: captures a throw on button
// release, scores it, alternates turns, declares a winner. DICE_HIST_EN adds face counters.
module dice_score_keeper
  import dice_pkg::*;
#(
  parameter int SCORE_W = 8,
  parameter int TARGET  = 50
) (
  input  logic                clk,
  input  logic                rst,
  dice_score_keeper_if.slave  bus
);
  state_t             state, nxt;
  logic               press, rel;
  logic [2:0]         cap;
  logic               player;
  logic [SCORE_W-1:0] s0, s1, cur, sat;
  logic [SCORE_W:0]   sum;
  logic [2:0]         last;
  logic               rv, bad, win;
  logic               clr;

  dice_release_det u_det (
    .clk    (clk),
    .rst    (rst),
    .button (bus.button),
    .press  (press),
    .rel    (rel)
  );

  assign clr = bus.new_game;
  assign cur = player ? s1 : s0;
  assign sum = {1'b0, cur} + {{(SCORE_W-2){1'b0}}, cap};
  assign sat = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (press) nxt = ROLLING;
      ROLLING: if (rel)   nxt = SCORE;
      SCORE:   nxt = CHECK;
      CHECK:   nxt = (cur >= SCORE_W'(TARGET)) ? DONE : IDLE;
      DONE:    nxt = DONE;
      default: nxt = IDLE;
    endcase
    if (clr) nxt = IDLE;
  end

  // A throw released in the same cycle as new_game is dropped by the clear branch.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cap    <= 3'd0;
      player <= 1'b0;
      s0     <= '0;
      s1     <= '0;
      last   <= 3'd0;
      rv     <= 1'b0;
      bad    <= 1'b0;
      win    <= 1'b0;
    end else begin
      rv  <= 1'b0;
      bad <= 1'b0;
      case (state)
        ROLLING: if (rel) cap <= bus.throw;
        SCORE: begin
          if (face_ok(cap)) begin
            if (player) s1 <= sat;
            else        s0 <= sat;
            last <= cap;
            rv   <= 1'b1;
          end else begin
            bad <= 1'b1;
          end
        end
        CHECK: begin
          if (cur >= SCORE_W'(TARGET))                     win    <= player;
          else if (face_ok(cap) && (cap != BONUS_FACE))    player <= ~player;
        end
        default: ;
      endcase
    end
  end

  assign bus.player       = player;
  assign bus.score0       = s0;
  assign bus.score1       = s1;
  assign bus.last_throw   = last;
  assign bus.result_valid = rv;
  assign bus.bad_throw    = bad;
  assign bus.game_over    = (state == DONE);
  assign bus.winner       = win;

`ifdef DICE_HIST_EN
  logic [NUM_FACES-1:0][HIST_W-1:0] hist;
  logic                             hinc;

  // Counts the same event that raises result_valid; survives new_game.
  assign hinc = (state == SCORE) && face_ok(cap) && !clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else begin
      for (int i = 0; i < NUM_FACES; i++)
        if (hinc && (cap == 3'(i + 1)) && (hist[i] != {HIST_W{1'b1}}))
          hist[i] <= hist[i] + 1'b1;
    end
  end

  always_comb begin
    bus.hist_count = '0;
    for (int i = 0; i < NUM_FACES; i++)
      if (bus.hist_sel == 3'(i + 1)) bus.hist_count = hist[i];
  end
`endif

endmodule
